branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 2, number of cycles EX stays blocked after a redirect handshake; legal range 0..15.
REQ-002 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port resetn  in  1  asynchronous, active-low reset.
REQ-004 Port ex_valid  in  1  EX holds a resolved instruction this cycle.
REQ-005 Port ex_op_type  in  3  EX op type; only `OP_TYPE_BJ is acted on.
REQ-006 Port ex_branch  in  1  resolved taken flag from the EX branch resolver.
REQ-007 Port ex_pc  in  32  PC of the EX instruction.
REQ-008 Port ex_target  in  32  resolved branch/jump target.
REQ-009 Port ex_pred_taken  in  1  fetch-time prediction: taken.
REQ-010 Port ex_pred_target  in  32  fetch-time predicted target.
REQ-011 Port ex_ready  out  1  controller accepts the EX result; EX stalls when 0.
REQ-012 Port redir_valid  out  1  redirect request to fetch.
REQ-013 Port redir_pc  out  32  corrected fetch PC.
REQ-014 Port redir_ready  in  1  fetch accepts the redirect.
REQ-015 Port flush  out  1  kills IF/ID contents; one-cycle pulse.
REQ-016 Port bpu_upd_valid  out  1  predictor update strobe; one-cycle pulse.
REQ-017 Port bpu_upd_pc / bpu_upd_taken / bpu_upd_target  out  32/1/32  predictor update payload.
REQ-018 Port mispred_cnt  out  32  count of detected mispredictions.

Function
REQ-019 Accept event = ex_valid & ex_ready & (ex_op_type == `OP_TYPE_BJ); non-BJ ops and ex_valid=0 cause no action.
REQ-020 Mispredict = (ex_branch != ex_pred_taken) | (ex_branch & (ex_target != ex_pred_target)).
REQ-021 Correct PC = ex_branch ? ex_target : ex_pc + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-022 States IDLE, REDIRECT, DRAIN; ex_ready = 1 only in IDLE.
REQ-023 IDLE: accept with mispredict -> latch correct PC into redir_pc, go REDIRECT next cycle; accept without mispredict -> stay IDLE.
REQ-024 Every accept (mispredict or not) drives bpu_upd_valid = 1 in the following cycle with the registered pc, taken and target of that accept.
REQ-025 REDIRECT: redir_valid = 1, redir_pc stable; redir_ready = 0 -> hold; redir_ready = 1 -> handshake, flush = 1 in that same cycle, go DRAIN with counter = DRAIN_CYCLES, or IDLE directly if DRAIN_CYCLES = 0.
REQ-026 DRAIN: counter decrements each cycle; transition to IDLE in the cycle after counter reaches 1, so ex_ready is 0 for exactly DRAIN_CYCLES cycles after the handshake cycle.
REQ-027 redir_valid = 0 outside REDIRECT; flush = 0 except in the handshake cycle.
REQ-028 mispred_cnt increments by 1 on each mispredict accept and saturates at 0xFFFFFFFF.
REQ-029 Inputs are ignored while ex_ready = 0; a mispredict is never lost or doubled by stall cycles.
REQ-030 Latency from mispredict accept to redir_valid = 1 is exactly one cycle.

Reset
REQ-031 resetn = 0 immediately, regardless of clk: state IDLE, counter 0, redir_valid 0, redir_pc 0, flush 0, bpu_upd_valid 0, bpu_upd payload 0, mispred_cnt 0; ex_ready = 1 after release.
REQ-032 Reset in REDIRECT or DRAIN abandons the pending redirect; no redir_valid or flush is issued after release.

Verification
REQ-033 Correct prediction: BJ, ex_branch=1, pred_taken=1, target=pred_target=0x1000 -> bpu_upd_valid pulse next cycle, no redir_valid, mispred_cnt unchanged.
REQ-034 Not-taken mispredict: ex_pc=0x2000, ex_branch=0, pred_taken=1 -> redir_valid next cycle with redir_pc=0x2004, mispred_cnt=1.
REQ-035 Backpressure: redir_ready held 0 for 3 cycles then 1 -> redir_valid/redir_pc stable 3 cycles, flush single pulse on handshake, ex_ready 0 for 2 further cycles (DRAIN_CYCLES=2), then 1.
REQ-036 Wrong target: ex_branch=1, pred_taken=1, target=0x3000, pred_target=0x3400 -> redir_pc=0x3000; also ex_pc=0xFFFFFFFC not taken mispredict -> redir_pc=0x0.
REQ-037 Reset mid-REDIRECT: resetn low while redir_valid=1 -> all outputs cleared asynchronously, no flush after release.
REQ-038 Non-BJ op with ex_branch=1 and mismatched prediction -> no update pulse, no redirect, counter unchanged.

Source files
------------

// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl
//   Branch/jump resolution controller sitting behind the EX stage. It compares
//   each resolved branch/jump against the fetch-time prediction, trains the
//   predictor on every resolved BJ op, and on a mispredict issues a redirect
//   to fetch, flushes IF/ID on the redirect handshake, then holds EX for
//   DRAIN_CYCLES cycles while the front end refills.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   ex_valid/ex_op_type    EX result qualifier and op class
//   ex_branch/ex_target    resolved taken flag and target
//   ex_pc                  PC of the resolved instruction
//   ex_pred_taken/_target  fetch-time prediction
//   ex_ready               EX result accepted (only while idle)
//   redir_valid/redir_pc   redirect request to fetch, corrected PC
//   redir_ready            fetch accepts the redirect
//   flush                  IF/ID kill pulse, asserted in the handshake cycle
//   bpu_upd_*              one-cycle predictor update strobe and payload
//   mispred_cnt            saturating mispredict counter
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef OP_TYPE_BJ
`define OP_TYPE_BJ 3'd2
`endif

module branch_ctrl #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid,
    input  logic [2:0]  ex_op_type,
    input  logic        ex_branch,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        ex_ready,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready,
    output logic        flush,
    output logic        bpu_upd_valid,
    output logic [31:0] bpu_upd_pc,
    output logic        bpu_upd_taken,
    output logic [31:0] bpu_upd_target,
    output logic [31:0] mispred_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        redir_valid_q;
    logic [31:0] redir_pc_q;
    logic        bpu_upd_valid_q;
    logic [31:0] bpu_upd_pc_q;
    logic        bpu_upd_taken_q;
    logic [31:0] bpu_upd_target_q;
    logic [31:0] mispred_cnt_q;

    logic        accept_d;
    logic        mispred_d;
    logic [31:0] correct_pc_d;
    logic        handshake_d;

    // EX is only accepted while idle; stall cycles therefore can never
    // produce a second accept of the same instruction.
    assign ex_ready     = (state_q == IDLE);
    assign accept_d     = ex_valid & ex_ready & (ex_op_type == `OP_TYPE_BJ);
    assign mispred_d    = (ex_branch != ex_pred_taken) |
                          (ex_branch & (ex_target != ex_pred_target));
    // 32-bit add wraps naturally: 0xFFFFFFFC + 4 -> 0.
    assign correct_pc_d = ex_branch ? ex_target : (ex_pc + 32'd4);
    assign handshake_d  = redir_valid_q & redir_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            redir_valid_q    <= 1'b0;
            redir_pc_q       <= '0;
            bpu_upd_valid_q  <= 1'b0;
            bpu_upd_pc_q     <= '0;
            bpu_upd_taken_q  <= 1'b0;
            bpu_upd_target_q <= '0;
            mispred_cnt_q    <= '0;
        end else begin
            bpu_upd_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        bpu_upd_valid_q  <= 1'b1;
                        bpu_upd_pc_q     <= ex_pc;
                        bpu_upd_taken_q  <= ex_branch;
                        bpu_upd_target_q <= ex_target;
                        if (mispred_d) begin
                            redir_valid_q <= 1'b1;
                            redir_pc_q    <= correct_pc_d;
                            state_q       <= REDIRECT;
                            if (mispred_cnt_q != 32'hFFFF_FFFF)
                                mispred_cnt_q <= mispred_cnt_q + 32'd1;
                        end
                    end
                end
                REDIRECT: begin
                    // redir_pc_q is left untouched so it stays stable under
                    // backpressure.
                    if (handshake_d) begin
                        redir_valid_q <= 1'b0;
                        cnt_q         <= 4'(DRAIN_CYCLES);
                        state_q       <= (DRAIN_CYCLES == 0) ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    // Leaving on cnt==1 gives exactly DRAIN_CYCLES blocked
                    // cycles after the handshake cycle.
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1)
                        state_q <= IDLE;
                end
                default: begin
                    state_q       <= IDLE;
                    redir_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // flush must coincide with the handshake cycle itself, so it is decoded
    // from the registered redirect request and the live ready.
    assign flush          = handshake_d;
    assign redir_valid    = redir_valid_q;
    assign redir_pc       = redir_pc_q;
    assign bpu_upd_valid  = bpu_upd_valid_q;
    assign bpu_upd_pc     = bpu_upd_pc_q;
    assign bpu_upd_taken  = bpu_upd_taken_q;
    assign bpu_upd_target = bpu_upd_target_q;
    assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
`timescale 1ns/1ps

`ifndef OP_TYPE_BJ
`define OP_TYPE_BJ 3'd2
`endif

module tb_branch_ctrl;

    localparam int DRAIN = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ex_valid = 1'b0;
    logic [2:0]  ex_op_type = 3'd0;
    logic        ex_branch = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;
    logic        ex_ready;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready = 1'b0;
    logic        flush;
    logic        bpu_upd_valid;
    logic [31:0] bpu_upd_pc;
    logic        bpu_upd_taken;
    logic [31:0] bpu_upd_target;
    logic [31:0] mispred_cnt;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_cnt = '0;

    branch_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .resetn(resetn),
        .ex_valid(ex_valid), .ex_op_type(ex_op_type), .ex_branch(ex_branch),
        .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_ready(ex_ready), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .redir_ready(redir_ready), .flush(flush),
        .bpu_upd_valid(bpu_upd_valid), .bpu_upd_pc(bpu_upd_pc),
        .bpu_upd_taken(bpu_upd_taken), .bpu_upd_target(bpu_upd_target),
        .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a BJ that mispredicts, to prove stalled inputs are ignored.
    task automatic drive_garbage();
        ex_valid       = 1'($urandom_range(0, 1));
        ex_op_type     = `OP_TYPE_BJ;
        ex_branch      = 1'b0;
        ex_pred_taken  = 1'b1;
        ex_pc          = $urandom;
        ex_target      = $urandom;
        ex_pred_target = $urandom;
    endtask

    // One transaction end to end; expectations come from the spec rules.
    task automatic do_txn(input logic bj, input logic br, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic pt,
                          input logic [31:0] ptgt, input int stall);
        logic        mis;
        logic [31:0] cpc;
        mis = bj & ((br != pt) | (br & (tgt != ptgt)));
        cpc = br ? tgt : pc + 32'd4;

        ex_valid       = 1'b1;
        ex_op_type     = bj ? `OP_TYPE_BJ : (`OP_TYPE_BJ ^ 3'(1 + $urandom_range(0, 6)));
        ex_branch      = br;
        ex_pc          = pc;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
        redir_ready    = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if (ex_ready !== 1'b1 || flush !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready got ready=%b flush=%b want ready=1 flush=0", ex_ready, flush);
        end
        tick();
        if (mis && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
        if (mis) drive_garbage();
        else ex_valid = 1'b0;

        checks++;
        if (bpu_upd_valid !== bj) begin
            errors++;
            $display("FAIL bpu_pulse got %b want %b", bpu_upd_valid, bj);
        end
        if (bj) begin
            checks++;
            if (bpu_upd_pc !== pc || bpu_upd_taken !== br || bpu_upd_target !== tgt) begin
                errors++;
                $display("FAIL bpu_payload got pc=%h t=%b tg=%h want pc=%h t=%b tg=%h",
                         bpu_upd_pc, bpu_upd_taken, bpu_upd_target, pc, br, tgt);
            end
        end
        checks++;
        if (redir_valid !== mis || ex_ready !== !mis || mispred_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL post_accept got rv=%b rdy=%b cnt=%0d want rv=%b rdy=%b cnt=%0d",
                     redir_valid, ex_ready, mispred_cnt, mis, !mis, exp_cnt);
        end
        if (mis) begin
            checks++;
            if (redir_pc !== cpc) begin
                errors++;
                $display("FAIL redir_pc got %h want %h", redir_pc, cpc);
            end
            for (int k = 0; k < stall; k++) begin
                redir_ready = 1'b0;
                #1;
                checks++;
                if (redir_valid !== 1'b1 || redir_pc !== cpc || flush !== 1'b0 || ex_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL backpressure got rv=%b pc=%h fl=%b rdy=%b want rv=1 pc=%h fl=0 rdy=0",
                             redir_valid, redir_pc, flush, ex_ready, cpc);
                end
                tick();
                drive_garbage();
                checks++;
                if (bpu_upd_valid !== 1'b0 || mispred_cnt !== exp_cnt) begin
                    errors++;
                    $display("FAIL stall_ignore got bpu=%b cnt=%0d want bpu=0 cnt=%0d",
                             bpu_upd_valid, mispred_cnt, exp_cnt);
                end
            end
            redir_ready = 1'b1;
            #1;
            checks++;
            if (flush !== 1'b1 || redir_valid !== 1'b1 || redir_pc !== cpc) begin
                errors++;
                $display("FAIL handshake got fl=%b rv=%b pc=%h want fl=1 rv=1 pc=%h",
                         flush, redir_valid, redir_pc, cpc);
            end
            tick();
            redir_ready = 1'($urandom_range(0, 1));
            for (int d = 0; d < DRAIN; d++) begin
                drive_garbage();
                #1;
                checks++;
                if (ex_ready !== 1'b0 || redir_valid !== 1'b0 || flush !== 1'b0 || bpu_upd_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL drain%0d got rdy=%b rv=%b fl=%b bpu=%b want all 0",
                             d, ex_ready, redir_valid, flush, bpu_upd_valid);
                end
                tick();
            end
            ex_valid = 1'b0;
            #1;
            checks++;
            if (ex_ready !== 1'b1 || mispred_cnt !== exp_cnt || redir_valid !== 1'b0) begin
                errors++;
                $display("FAIL drain_exit got rdy=%b cnt=%0d rv=%b want rdy=1 cnt=%0d rv=0",
                         ex_ready, mispred_cnt, redir_valid, exp_cnt);
            end
        end else begin
            tick();
            checks++;
            if (bpu_upd_valid !== 1'b0 || redir_valid !== 1'b0) begin
                errors++;
                $display("FAIL pulse_end got bpu=%b rv=%b want 0 0", bpu_upd_valid, redir_valid);
            end
        end
        redir_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        checks++;
        if (ex_ready !== 1'b1 || redir_valid !== 1'b0 || redir_pc !== 32'h0 || flush !== 1'b0 ||
            bpu_upd_valid !== 1'b0 || bpu_upd_pc !== 32'h0 || bpu_upd_taken !== 1'b0 ||
            bpu_upd_target !== 32'h0 || mispred_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b rv=%b pc=%h fl=%b bpu=%b cnt=%0d",
                     ex_ready, redir_valid, redir_pc, flush, bpu_upd_valid, mispred_cnt);
        end
        exp_cnt = '0;
    endtask

    task automatic test_correct_pred();
        do_txn(1'b1, 1'b1, 32'h0000_0F00, 32'h1000, 1'b1, 32'h1000, 0);
        do_txn(1'b1, 1'b0, 32'h0000_0F10, 32'h1000, 1'b0, 32'h5555, 0);
    endtask

    task automatic test_not_taken_mispred();
        do_txn(1'b1, 1'b0, 32'h2000, 32'h9000, 1'b1, 32'h9000, 0);
        checks++;
        if (mispred_cnt !== 32'd1) begin
            errors++;
            $display("FAIL first_mispred_cnt got %0d want 1", mispred_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_txn(1'b1, 1'b1, 32'h2400, 32'h7000, 1'b0, 32'h0, 3);
    endtask

    task automatic test_wrong_target();
        do_txn(1'b1, 1'b1, 32'h2800, 32'h3000, 1'b1, 32'h3400, 1);
        do_txn(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h1234, 1'b1, 32'h1234, 0);
    endtask

    task automatic test_non_bj();
        do_txn(1'b0, 1'b1, 32'h4000, 32'h5000, 1'b0, 32'h6000, 0);
        checks++;
        if (mispred_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL non_bj_cnt got %0d want %0d", mispred_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_redirect();
        do_txn(1'b1, 1'b1, 32'h8000, 32'h8800, 1'b1, 32'h8000, 2);
        ex_valid = 1'b1; ex_op_type = `OP_TYPE_BJ; ex_branch = 1'b1;
        ex_pc = 32'hA000; ex_target = 32'hB000;
        ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
        redir_ready = 1'b0;
        tick();
        ex_valid = 1'b0;
        checks++;
        if (redir_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_redirect got %b want 1", redir_valid);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (redir_valid !== 1'b0 || redir_pc !== 32'h0 || flush !== 1'b0 ||
            bpu_upd_valid !== 1'b0 || bpu_upd_pc !== 32'h0 || mispred_cnt !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got rv=%b pc=%h fl=%b bpu=%b cnt=%0d want all 0",
                     redir_valid, redir_pc, flush, bpu_upd_valid, mispred_cnt);
        end
        exp_cnt = '0;
        redir_ready = 1'b1;
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (redir_valid !== 1'b0 || flush !== 1'b0 || ex_ready !== 1'b1) begin
                errors++;
                $display("FAIL post_reset%0d got rv=%b fl=%b rdy=%b want 0 0 1",
                         i, redir_valid, flush, ex_ready);
            end
        end
        redir_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic        bj, br, pt;
            logic [31:0] pc, tgt, ptgt;
            bj   = ($urandom_range(0, 3) != 0);
            br   = 1'($urandom_range(0, 1));
            pt   = 1'($urandom_range(0, 1));
            pc   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            tgt  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            ptgt = ($urandom_range(0, 1) != 0) ? tgt : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if (n == 7) pc = 32'hFFFF_FFFC;
            do_txn(bj, br, pc, tgt, pt, ptgt, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_correct_pred();
        test_not_taken_mispred();
        test_backpressure();
        test_wrong_target();
        test_non_bj();
        test_reset_mid_redirect();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
